// File: rtl/riscv_mem.sv
// ============================================================================
//  Module      : riscv_mem
//  Description : Memory-access pipeline stage between EX and WB. Single-entry
//                holding register with an IDLE/ALU/LD/ST request machine that
//                initiates data_bif bus reads/writes and presents the entry
//                to writeback over the mem_wb_* handshake. Load data is not
//                captured here; WB samples data_bif_rdata on data_bif_ack.
//                Optional macro RISCV_MEM_MISALIGN_TRAP_EN adds the
//                mem_exc_misalign output and turns misaligned accesses into
//                bus-less NOP entries.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_mem (
    input  logic        clk,
    input  logic        rstn,
    // EX -> MEM entry
    input  logic        ex_mem_rdy,
    output logic        ex_mem_ack,
    input  logic [3:0]  ex_mem_funct,
    input  logic [31:0] ex_mem_data,
    input  logic [31:0] ex_mem_wdata,
    input  logic [4:0]  ex_mem_rsd,
    // data bus initiator
    output logic        data_bif_req,
    output logic        data_bif_rnw,
    output logic [31:0] data_bif_addr,
    output logic [3:0]  data_bif_wmask,
    output logic [31:0] data_bif_wdata,
    input  logic        data_bif_ack,
    // MEM -> WB entry
    output logic        mem_wb_rdy,
    input  logic        mem_wb_ack,
    output logic [2:0]  mem_wb_funct,
    output logic [31:0] mem_wb_data,
    output logic [4:0]  mem_wb_rsd
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
    ,
    output logic        mem_exc_misalign
`endif
);

    // EX-side operation codes
    localparam logic [3:0] c_FN_LB  = 4'd1;
    localparam logic [3:0] c_FN_LH  = 4'd2;
    localparam logic [3:0] c_FN_LW  = 4'd3;
    localparam logic [3:0] c_FN_LHU = 4'd5;
    localparam logic [3:0] c_FN_SB  = 4'd6;
    localparam logic [3:0] c_FN_SH  = 4'd7;
    localparam logic [3:0] c_FN_SW  = 4'd8;

    // WB-side load code for non-load entries
    localparam logic [2:0] c_LD_NOP = 3'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ALU  = 2'd1,
        S_LD   = 2'd2,
        S_ST   = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_req;
    logic        r_rnw;
    logic [31:0] r_addr;
    logic [3:0]  r_wmask;
    logic [31:0] r_wdata;
    logic        r_wb_rdy;
    logic [2:0]  r_wb_funct;
    logic [31:0] r_wb_data;
    logic [4:0]  r_wb_rsd;

    logic        w_retire;
    logic        w_accept;
    logic        w_is_ld;
    logic        w_is_st;
    logic        w_misalign;
    logic [3:0]  w_wmask;
    logic [31:0] w_bwdata;

    // Retire condition of the entry currently held
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_ALU:   w_retire = r_wb_rdy && mem_wb_ack;
            S_LD:    w_retire = data_bif_ack && mem_wb_ack;
            S_ST:    w_retire = data_bif_ack;
            default: w_retire = 1'b0;
        endcase
    end

    // Accept when empty or when the held entry leaves this cycle; held low in reset
    assign ex_mem_ack = rstn && ((r_state == S_IDLE) || w_retire);
    assign w_accept   = ex_mem_rdy && ex_mem_ack;

    // Decode the incoming operation: class, misalignment, byte lanes, store data
    always_comb begin
        w_is_ld    = (ex_mem_funct >= c_FN_LB) && (ex_mem_funct <= c_FN_LHU);
        w_is_st    = (ex_mem_funct >= c_FN_SB) && (ex_mem_funct <= c_FN_SW);
        w_misalign = 1'b0;
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
        case (ex_mem_funct)
            c_FN_LH, c_FN_LHU, c_FN_SH: w_misalign = ex_mem_data[0];
            c_FN_LW, c_FN_SW:           w_misalign = |ex_mem_data[1:0];
            default:                    w_misalign = 1'b0;
        endcase
`endif
        w_wmask  = 4'hF;
        w_bwdata = ex_mem_wdata;
        case (ex_mem_funct)
            c_FN_SB: begin
                w_wmask  = 4'b0001 << ex_mem_data[1:0];
                w_bwdata = {4{ex_mem_wdata[7:0]}};
            end
            c_FN_SH: begin
                w_wmask  = 4'b0011 << {ex_mem_data[1], 1'b0};
                w_bwdata = {2{ex_mem_wdata[15:0]}};
            end
            default: begin
                w_wmask  = 4'hF;
                w_bwdata = ex_mem_wdata;
            end
        endcase
    end

    // Entry state machine; every bus and WB output is a register loaded on accept
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_rnw      <= 1'b0;
            r_addr     <= 32'd0;
            r_wmask    <= 4'd0;
            r_wdata    <= 32'd0;
            r_wb_rdy   <= 1'b0;
            r_wb_funct <= c_LD_NOP;
            r_wb_data  <= 32'd0;
            r_wb_rsd   <= 5'd0;
        end else if (w_accept) begin
            // Start from an all-quiet entry and fill in what the new state uses
            r_req      <= 1'b0;
            r_rnw      <= 1'b0;
            r_addr     <= 32'd0;
            r_wmask    <= 4'd0;
            r_wdata    <= 32'd0;
            r_wb_rdy   <= 1'b0;
            r_wb_funct <= c_LD_NOP;
            r_wb_data  <= 32'd0;
            r_wb_rsd   <= 5'd0;
            if (w_is_ld && !w_misalign) begin
                r_state    <= S_LD;
                r_req      <= 1'b1;
                r_rnw      <= 1'b1;
                r_addr     <= {ex_mem_data[31:2], 2'b00};
                r_wb_rdy   <= 1'b1;
                r_wb_funct <= ex_mem_funct[2:0];
                r_wb_data  <= ex_mem_data;
                r_wb_rsd   <= ex_mem_rsd;
            end else if (w_is_st && !w_misalign) begin
                r_state    <= S_ST;
                r_req      <= 1'b1;
                r_addr     <= {ex_mem_data[31:2], 2'b00};
                r_wmask    <= w_wmask;
                r_wdata    <= w_bwdata;
            end else begin
                // ALU result, unknown codes, and trapped misaligned accesses
                r_state    <= S_ALU;
                r_wb_rdy   <= 1'b1;
                r_wb_data  <= ex_mem_data;
                r_wb_rsd   <= w_misalign ? 5'd0 : ex_mem_rsd;
            end
        end else if (w_retire) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_rnw      <= 1'b0;
            r_addr     <= 32'd0;
            r_wmask    <= 4'd0;
            r_wdata    <= 32'd0;
            r_wb_rdy   <= 1'b0;
            r_wb_funct <= c_LD_NOP;
            r_wb_data  <= 32'd0;
            r_wb_rsd   <= 5'd0;
        end
    end

`ifdef RISCV_MEM_MISALIGN_TRAP_EN
    logic r_exc;

    // One-cycle trap pulse the cycle after a misaligned entry is accepted
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_exc <= 1'b0;
        end else begin
            r_exc <= w_accept && w_misalign;
        end
    end

    assign mem_exc_misalign = r_exc;
`endif

    assign data_bif_req   = r_req;
    assign data_bif_rnw   = r_rnw;
    assign data_bif_addr  = r_addr;
    assign data_bif_wmask = r_wmask;
    assign data_bif_wdata = r_wdata;
    assign mem_wb_rdy     = r_wb_rdy;
    assign mem_wb_funct   = r_wb_funct;
    assign mem_wb_data    = r_wb_data;
    assign mem_wb_rsd     = r_wb_rsd;

endmodule

`default_nettype wire

// File: tb/tb_riscv_mem.sv
// ============================================================================
//  Module      : tb_riscv_mem
//  Description : Scoreboard bench for riscv_mem. Accepted operations push
//                expected bus and WB entries; a negedge monitor compares the
//                DUT outputs against the queue heads and pops on handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_mem;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ex_mem_rdy = 1'b0;
    logic        ex_mem_ack;
    logic [3:0]  ex_mem_funct = 4'd0;
    logic [31:0] ex_mem_data = 32'd0;
    logic [31:0] ex_mem_wdata = 32'd0;
    logic [4:0]  ex_mem_rsd = 5'd0;
    logic        data_bif_req;
    logic        data_bif_rnw;
    logic [31:0] data_bif_addr;
    logic [3:0]  data_bif_wmask;
    logic [31:0] data_bif_wdata;
    logic        data_bif_ack = 1'b0;
    logic        mem_wb_rdy;
    logic        mem_wb_ack = 1'b0;
    logic [2:0]  mem_wb_funct;
    logic [31:0] mem_wb_data;
    logic [4:0]  mem_wb_rsd;
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
    logic        mem_exc_misalign;
`endif

    riscv_mem u_dut (
        .clk            (clk),
        .rstn           (rstn),
        .ex_mem_rdy     (ex_mem_rdy),
        .ex_mem_ack     (ex_mem_ack),
        .ex_mem_funct   (ex_mem_funct),
        .ex_mem_data    (ex_mem_data),
        .ex_mem_wdata   (ex_mem_wdata),
        .ex_mem_rsd     (ex_mem_rsd),
        .data_bif_req   (data_bif_req),
        .data_bif_rnw   (data_bif_rnw),
        .data_bif_addr  (data_bif_addr),
        .data_bif_wmask (data_bif_wmask),
        .data_bif_wdata (data_bif_wdata),
        .data_bif_ack   (data_bif_ack),
        .mem_wb_rdy     (mem_wb_rdy),
        .mem_wb_ack     (mem_wb_ack),
        .mem_wb_funct   (mem_wb_funct),
        .mem_wb_data    (mem_wb_data),
        .mem_wb_rsd     (mem_wb_rsd)
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
        ,
        .mem_exc_misalign (mem_exc_misalign)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int exc_cyc = -10;

    // Responder configuration (written by main only)
    int lat_cfg = 0;      // <0: random 0..3 wait cycles per transfer
    bit no_ack = 1'b0;    // hold the bus off completely
    bit wb_always = 1'b1; // WB accepts every cycle
    int spur = 0;         // ack while req=0: 0 never, 1 random, 2 always

    // Responder state
    int wait_cnt = 0;
    int cur_lat = 0;

    // Expected {req,rnw,addr,wmask,wdata} and {rdy,funct,data,rsd}
    logic [69:0] bq[$];
    logic [40:0] wq[$];
    logic [69:0] bact;
    logic [40:0] wact;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus slave and WB consumer
    always @(posedge clk) begin
        #1;
        if (!rstn) begin
            wait_cnt     = 0;
            data_bif_ack = 1'b0;
            mem_wb_ack   = 1'b0;
        end else if (data_bif_req && !no_ack) begin
            if (wait_cnt == 0)
                cur_lat = (lat_cfg >= 0) ? lat_cfg : int'($urandom_range(0, 3));
            if (wait_cnt >= cur_lat) begin
                data_bif_ack = 1'b1;
                wait_cnt     = 0;
            end else begin
                data_bif_ack = 1'b0;
                wait_cnt++;
            end
            mem_wb_ack = data_bif_rnw ? data_bif_ack : ($urandom_range(0, 1) == 1);
        end else begin
            data_bif_ack = (spur == 2) || (spur == 1 && $urandom_range(0, 7) == 0);
            mem_wb_ack   = wb_always || ($urandom_range(0, 1) == 1);
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rstn) begin
            bact = {data_bif_req, data_bif_rnw, data_bif_addr, data_bif_wmask, data_bif_wdata};
            wact = {mem_wb_rdy, mem_wb_funct, mem_wb_data, mem_wb_rsd};
            if (bq.size() > 0) chk("bus", bact, bq[0]);
            else               chk("bus_idle", bact, 70'd0);
            if (wq.size() > 0) chk("wb", {29'd0, wact}, {29'd0, wq[0]});
            else               chk("wb_idle", {29'd0, wact}, 70'd0);
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
            chk("exc", {69'd0, mem_exc_misalign}, {69'd0, (cyc == exc_cyc)});
`endif
            if (data_bif_req && data_bif_ack && bq.size() > 0) bq.delete(0);
            if (mem_wb_rdy && mem_wb_ack && wq.size() > 0) wq.delete(0);
        end
    end

    // Present one operation, wait for acceptance, then record what must follow
    task automatic issue(input logic [3:0] f, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd);
        bit done;
        bit mis;
        logic [3:0]  m;
        logic [31:0] bw;
        ex_mem_rdy   = 1'b1;
        ex_mem_funct = f;
        ex_mem_data  = a;
        ex_mem_wdata = wd;
        ex_mem_rsd   = rd;
        done = 1'b0;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            if (ex_mem_ack) begin
                done    = 1'b1;
                acc_cyc = cyc;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got no ex_mem_ack expected ack within 40 cycles");
            @(posedge clk);
        end else begin
            @(posedge clk);
            mis = 1'b0;
`ifdef RISCV_MEM_MISALIGN_TRAP_EN
            if ((f == 4'd2 || f == 4'd5 || f == 4'd7) && a[0]) mis = 1'b1;
            if ((f == 4'd3 || f == 4'd8) && (a % 4 != 0))      mis = 1'b1;
`endif
            if (mis) begin
                wq.push_back({1'b1, 3'd0, a, 5'd0});
                exc_cyc = acc_cyc + 1;
            end else if (f >= 4'd1 && f <= 4'd5) begin
                bq.push_back({1'b1, 1'b1, a & 32'hFFFF_FFFC, 4'd0, 32'd0});
                wq.push_back({1'b1, f[2:0], a, rd});
            end else if (f >= 4'd6 && f <= 4'd8) begin
                if (f == 4'd6) begin
                    m  = 4'(1 << (a % 4));
                    bw = (wd & 32'hFF) * 32'h0101_0101;
                end else if (f == 4'd7) begin
                    m  = 4'(3 << (a & 2));
                    bw = (wd & 32'hFFFF) * 32'h0001_0001;
                end else begin
                    m  = 4'hF;
                    bw = wd;
                end
                bq.push_back({1'b1, 1'b0, a & 32'hFFFF_FFFC, m, bw});
            end else begin
                wq.push_back({1'b1, 3'd0, a, rd});
            end
        end
        #1;
        ex_mem_rdy = 1'b0;
    endtask

    // Let all outstanding entries complete
    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 60 && !ok; t++) begin
            @(negedge clk);
            ok = (bq.size() == 0) && (wq.size() == 0);
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d/%0d entries pending expected 0/0", bq.size(), wq.size());
            bq.delete();
            wq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    int first_acc;
    logic [3:0] rf;

    initial begin
        // Reset state, then release
        #12;
        chk("reset_outputs", {ex_mem_ack, data_bif_req, data_bif_rnw, data_bif_addr, data_bif_wmask,
                              mem_wb_rdy, mem_wb_funct, mem_wb_data[27:0]}, 70'd0);
        @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        chk("ack_after_reset", {69'd0, ex_mem_ack}, 70'd1);
        @(posedge clk);
        #1;

        // ALU op
        issue(4'd0, 32'h1234, 32'd0, 5'd5);
        drain();

        // LW with three request cycles
        lat_cfg = 2;
        issue(4'd3, 32'h100, 32'd0, 5'd7);
        drain();

        // Byte and halfword stores
        lat_cfg = 0;
        issue(4'd6, 32'h203, 32'h0000_00AB, 5'd1);
        issue(4'd7, 32'h202, 32'h0000_BEEF, 5'd2);
        drain();

        // Zero-wait back-to-back mix: one accept every cycle
        issue(4'd1, 32'h10, 32'd0, 5'd3);
        first_acc = acc_cyc;
        issue(4'd8, 32'h20, 32'h1122_3344, 5'd4);
        issue(4'd0, 32'hCAFE, 32'd0, 5'd9);
        issue(4'd5, 32'h46, 32'd0, 5'd10);
        issue(4'd7, 32'h31, 32'h0000_5A5A, 5'd0);
        issue(4'd12, 32'h777, 32'd0, 5'd11);
        issue(4'd4, 32'h53, 32'd0, 5'd12);
        issue(4'd2, 32'h66, 32'd0, 5'd13);
        issue(4'd6, 32'h7F, 32'h0000_00C3, 5'd14);
        issue(4'd3, 32'h88, 32'd0, 5'd15);
        chk("throughput", 70'(acc_cyc - first_acc), 70'd9);
        drain();

        // Reset while a load is outstanding, then a late ack must be ignored
        no_ack = 1'b1;
        issue(4'd3, 32'h300, 32'd0, 5'd6);
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        chk("async_reset", {ex_mem_ack, data_bif_req, data_bif_rnw, data_bif_addr, data_bif_wmask,
                            mem_wb_rdy, mem_wb_funct, mem_wb_data[27:0]}, 70'd0);
        bq.delete();
        wq.delete();
        no_ack = 1'b0;
        spur = 2;
        @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        chk("ack_after_midreset", {69'd0, ex_mem_ack}, 70'd1);
        repeat (3) @(negedge clk);
        spur = 1;
        @(posedge clk);
        #1;

        // Randomized traffic with random wait states and WB back-pressure
        lat_cfg = -1;
        wb_always = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rf = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0) rf = 4'($urandom_range(1, 8));
            issue(rf, $urandom, $urandom, 5'($urandom_range(0, 31)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
